// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage_if
//  Description : Handshake and data bundle between the ALU core, the result
//                stage and the downstream consumer. The result stage takes
//                the slave side; the ALU core / consumer takes the master side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if;
    // Upstream channel (ALU core -> result stage)
    logic [7:0] alu_out;
    logic       carry_out;
    logic       half_carry_out;
    logic       overflow_out;
    logic [3:0] op;
    logic       dec_mode;
    logic       in_valid;
    logic       in_ready;
    // Downstream channel (result stage -> consumer)
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;

    modport master (
        output alu_out, carry_out, half_carry_out, overflow_out, op, dec_mode,
        output in_valid, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  alu_out, carry_out, half_carry_out, overflow_out, op, dec_mode,
        input  in_valid, out_ready,
        output in_ready, out_valid, result
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Captures an ALU core result, optionally applies the BCD
//                adjustment for decimal ADC/SBC, updates the {N,V,1,B,D,I,Z,C}
//                status register and presents the result on a valid/ready
//                output channel.
//  Config      : ALU_DECIMAL_EN - when defined, decimal ADC/SBC take one extra
//                cycle through the ADJ state; when undefined, dec_mode is
//                ignored and every op completes with its binary result.
//  Revision    : 1.0 - initial release
// ============================================================================

// Opcode encodings; an including design may supply its own before this file.
`ifndef ALU_ORA
`define ALU_ORA 4'h0
`endif
`ifndef ALU_AND
`define ALU_AND 4'h1
`endif
`ifndef ALU_EOR
`define ALU_EOR 4'h2
`endif
`ifndef ALU_ADC
`define ALU_ADC 4'h3
`endif
`ifndef ALU_SBC
`define ALU_SBC 4'h4
`endif
`ifndef ALU_ROR
`define ALU_ROR 4'h5
`endif
`ifndef ALU_PSA
`define ALU_PSA 4'h6
`endif

module alu_result_stage (
    input  logic               clk,
    input  logic               reset,
    alu_result_stage_if.slave  bus,
    input  logic               p_load,
    input  logic [7:0]         p_in,
    output logic [7:0]         p
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADJ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] C_P_RESET  = 8'h24;
    localparam logic [7:0] C_P_ONE    = 8'h20;

    state_t     r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [7:0] r_result;
    logic [7:0] r_p;

    // Hold registers captured on the input transfer
    logic [7:0] r_alu;
    logic       r_carry;
    logic       r_half;
    logic       r_ovf;
    logic [3:0] r_op;

    // Value/flags source for the edge that enters DONE
    logic [7:0] w_src_res;
    logic [3:0] w_src_op;
    logic       w_src_c;
    logic       w_src_v;
    logic [7:0] w_flag_p;
    logic       w_in_xfer;
    logic       w_go_adj;

    // Status register update: N/Z always, C for ADC/SBC/ROR, V for ADC/SBC.
    function automatic logic [7:0] f_flags(
        input logic [7:0] p_cur,
        input logic [7:0] res,
        input logic [3:0] op,
        input logic       c,
        input logic       v
    );
        logic [7:0] p_new;
        p_new    = p_cur;
        p_new[7] = res[7];
        p_new[1] = (res == 8'h00);
        if ((op == `ALU_ADC) || (op == `ALU_SBC) || (op == `ALU_ROR)) begin
            p_new[0] = c;
        end
        if ((op == `ALU_ADC) || (op == `ALU_SBC)) begin
            p_new[6] = v;
        end
        p_new[5] = 1'b1;
        return p_new;
    endfunction

    assign w_in_xfer = (r_state == S_IDLE) && bus.in_valid;

`ifdef ALU_DECIMAL_EN
    logic [3:0] w_adj_lo;
    logic [3:0] w_adj_hi;
    logic [7:0] w_adj;

    // BCD correction of the held binary result; each nibble wraps on its own.
    always_comb begin
        w_adj_lo = r_alu[3:0];
        w_adj_hi = r_alu[7:4];
        if (r_op == `ALU_ADC) begin
            if (r_half)   w_adj_lo = r_alu[3:0] + 4'h6;
            if (r_carry)  w_adj_hi = r_alu[7:4] + 4'h6;
        end else begin
            if (!r_half)  w_adj_lo = r_alu[3:0] + 4'hA;
            if (!r_carry) w_adj_hi = r_alu[7:4] + 4'hA;
        end
    end

    assign w_adj    = {w_adj_hi, w_adj_lo};
    assign w_go_adj = bus.dec_mode &&
                      ((bus.op == `ALU_ADC) || (bus.op == `ALU_SBC));

    // In ADJ the flags come from the held values and adjusted result;
    // otherwise straight from the bus on the capture edge.
    always_comb begin
        w_src_res = bus.alu_out;
        w_src_op  = bus.op;
        w_src_c   = bus.carry_out;
        w_src_v   = bus.overflow_out;
        if (r_state == S_ADJ) begin
            w_src_res = w_adj;
            w_src_op  = r_op;
            w_src_c   = r_carry;
            w_src_v   = r_ovf;
        end
    end
`else
    logic w_unused_hold;

    assign w_go_adj = 1'b0;

    // Binary-only build: the result and flags always come from the bus.
    always_comb begin
        w_src_res = bus.alu_out;
        w_src_op  = bus.op;
        w_src_c   = bus.carry_out;
        w_src_v   = bus.overflow_out;
    end

    // Hold registers and decimal inputs have no consumer in this build.
    assign w_unused_hold = &{1'b0, bus.dec_mode, bus.half_carry_out,
                             r_alu, r_carry, r_half, r_ovf, r_op};
`endif

    assign w_flag_p = f_flags(r_p, w_src_res, w_src_op, w_src_c, w_src_v);

    // Handshake FSM, hold capture, result and status register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 8'h00;
            r_p         <= C_P_RESET;
            r_alu       <= 8'h00;
            r_carry     <= 1'b0;
            r_half      <= 1'b0;
            r_ovf       <= 1'b0;
            r_op        <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_alu      <= bus.alu_out;
                        r_carry    <= bus.carry_out;
                        r_half     <= bus.half_carry_out;
                        r_ovf      <= bus.overflow_out;
                        r_op       <= bus.op;
                        r_in_ready <= 1'b0;
                        if (w_go_adj) begin
                            r_state <= S_ADJ;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_src_res;
                            r_p         <= w_flag_p;
                        end
                    end
                end
`ifdef ALU_DECIMAL_EN
                S_ADJ: begin
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                    r_result    <= w_src_res;
                    r_p         <= w_flag_p;
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
            // A direct status write takes precedence over any flag update.
            if (p_load) begin
                r_p <= p_in | C_P_ONE;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign p             = r_p;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Directed table-driven bench for alu_result_stage plus
//                hand-written sequences for backpressure, p_load priority
//                and reset abandonment.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef ALU_ORA
`define ALU_ORA 4'h0
`endif
`ifndef ALU_AND
`define ALU_AND 4'h1
`endif
`ifndef ALU_EOR
`define ALU_EOR 4'h2
`endif
`ifndef ALU_ADC
`define ALU_ADC 4'h3
`endif
`ifndef ALU_SBC
`define ALU_SBC 4'h4
`endif
`ifndef ALU_ROR
`define ALU_ROR 4'h5
`endif
`ifndef ALU_PSA
`define ALU_PSA 4'h6
`endif

module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_load;
    logic [7:0] p_in;
    logic [7:0] p;

    alu_result_stage_if bus ();

    alu_result_stage dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .p_load (p_load),
        .p_in   (p_in),
        .p      (p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] alu;
        logic       c;
        logic       h;
        logic       v;
        logic [3:0] op;
        logic       dec;
        logic [7:0] pinit;
        logic [7:0] res;
        logic [7:0] pexp;
        int         lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.alu_out        = v.alu;
        bus.carry_out      = v.c;
        bus.half_carry_out = v.h;
        bus.overflow_out   = v.v;
        bus.op             = v.op;
        bus.dec_mode       = v.dec;
    endtask

    // Scramble inputs after capture; the DUT must ignore them.
    task automatic scramble(input vec_t v);
        bus.alu_out        = ~v.alu;
        bus.carry_out      = ~v.c;
        bus.half_carry_out = ~v.h;
        bus.overflow_out   = ~v.v;
        bus.op             = v.op ^ 4'h1;
        bus.dec_mode       = ~v.dec;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        check({name, "_idle"}, {7'd0, bus.in_ready}, 8'h01);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        p_load = 1'b1;
        p_in   = v.pinit;
        tick();
        p_load = 1'b0;
        wait_idle(nm);
        @(negedge clk);
        drive(v);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        scramble(v);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 5) begin
            tick();
            lat++;
        end
        check({nm, "_lat"}, 8'(lat), 8'(v.lat));
        check({nm, "_result"}, bus.result, v.res);
        check({nm, "_p"}, p, v.pexp);
    endtask

    initial begin
        vec_t vb;
        //                alu    c     h     v     op        dec   pinit  res    p      lat
        vecs[0]  = '{8'hA0, 1'b0, 1'b0, 1'b1, `ALU_ADC, 1'b0, 8'h00, 8'hA0, 8'hE0, 1};
        vecs[3]  = '{8'h00, 1'b1, 1'b0, 1'b0, `ALU_ORA, 1'b0, 8'hC3, 8'h00, 8'h63, 1};
        vecs[4]  = '{8'h80, 1'b0, 1'b0, 1'b1, `ALU_AND, 1'b0, 8'h02, 8'h80, 8'hA0, 1};
        vecs[5]  = '{8'h01, 1'b1, 1'b0, 1'b1, `ALU_ROR, 1'b0, 8'h40, 8'h01, 8'h61, 1};
        vecs[6]  = '{8'hFF, 1'b1, 1'b0, 1'b1, `ALU_PSA, 1'b0, 8'h0C, 8'hFF, 8'hAC, 1};
        vecs[7]  = '{8'h00, 1'b1, 1'b0, 1'b0, `ALU_SBC, 1'b0, 8'hFF, 8'h00, 8'h3F, 1};
        vecs[9]  = '{8'h5A, 1'b0, 1'b0, 1'b0, `ALU_EOR, 1'b1, 8'h80, 8'h5A, 8'h20, 1};
        vecs[10] = '{8'hFF, 1'b0, 1'b0, 1'b1, `ALU_SBC, 1'b1, 8'h00, 8'h99, 8'hE0, 2};
`ifdef ALU_DECIMAL_EN
        vecs[1]  = '{8'h41, 1'b0, 1'b1, 1'b0, `ALU_ADC, 1'b1, 8'h00, 8'h47, 8'h20, 2};
        vecs[2]  = '{8'h2D, 1'b1, 1'b0, 1'b0, `ALU_SBC, 1'b1, 8'h00, 8'h27, 8'h21, 2};
        vecs[8]  = '{8'hAA, 1'b1, 1'b1, 1'b0, `ALU_ADC, 1'b1, 8'h00, 8'h00, 8'h23, 2};
`else
        vecs[1]  = '{8'h41, 1'b0, 1'b1, 1'b0, `ALU_ADC, 1'b1, 8'h00, 8'h41, 8'h20, 1};
        vecs[2]  = '{8'h2D, 1'b1, 1'b0, 1'b0, `ALU_SBC, 1'b1, 8'h00, 8'h2D, 8'h21, 1};
        vecs[8]  = '{8'hAA, 1'b1, 1'b1, 1'b0, `ALU_ADC, 1'b1, 8'h00, 8'hAA, 8'hA1, 1};
        vecs[10] = '{8'hFF, 1'b0, 1'b0, 1'b1, `ALU_SBC, 1'b1, 8'h00, 8'hFF, 8'hE0, 1};
`endif

        reset         = 1'b1;
        p_load        = 1'b0;
        p_in          = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(vecs[0]);

        // Reset state
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_out_valid", {7'd0, bus.out_valid}, 8'h00);
        check("rst_in_ready",  {7'd0, bus.in_ready},  8'h01);
        check("rst_result",    bus.result, 8'h00);
        check("rst_p",         p, 8'h24);

        // Direct status write forces bit 5
        @(negedge clk);
        p_load = 1'b1;
        p_in   = 8'hDF;
        tick();
        p_load = 1'b0;
        check("pload_bit5", p, 8'hFF);

        // Main table
        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // Backpressure: DONE held for 3 cycles with out_ready low
        tick();
        wait_idle("bp");
        @(negedge clk);
        bus.out_ready = 1'b0;
        vb = '{8'h11, 1'b0, 1'b0, 1'b0, `ALU_ORA, 1'b0, 8'h00, 8'h11, 8'h20, 1};
        drive(vb);
        bus.in_valid = 1'b1;
        tick();
        bus.alu_out = 8'h99;
        check("bp_valid0", {7'd0, bus.out_valid}, 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_valid",  {7'd0, bus.out_valid}, 8'h01);
            check("bp_result", bus.result, 8'h11);
            check("bp_ready",  {7'd0, bus.in_ready}, 8'h00);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", {7'd0, bus.out_valid}, 8'h00);
        check("bp_release_ready", {7'd0, bus.in_ready},  8'h01);

        // p_load coincident with the flag update: load wins
        @(negedge clk);
        vb = '{8'h00, 1'b1, 1'b0, 1'b1, `ALU_ADC, 1'b0, 8'h00, 8'h00, 8'h20, 1};
        drive(vb);
        bus.in_valid = 1'b1;
        p_load       = 1'b1;
        p_in         = 8'h00;
        tick();
        bus.in_valid = 1'b0;
        p_load       = 1'b0;
        check("plw_p",      p, 8'h20);
        check("plw_valid",  {7'd0, bus.out_valid}, 8'h01);
        check("plw_result", bus.result, 8'h00);
        tick();

        // Reset while the operation is in flight (ADJ when decimal is built)
        wait_idle("rip");
        @(negedge clk);
        bus.out_ready = 1'b0;
        vb = '{8'h80, 1'b0, 1'b0, 1'b0, `ALU_ADC, 1'b1, 8'h00, 8'h80, 8'hA0, 2};
        drive(vb);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
`ifdef ALU_DECIMAL_EN
        check("rip_adj_valid", {7'd0, bus.out_valid}, 8'h00);
`endif
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        check("rip_valid",  {7'd0, bus.out_valid}, 8'h00);
        check("rip_p",      p, 8'h24);
        check("rip_result", bus.result, 8'h00);
        check("rip_ready",  {7'd0, bus.in_ready}, 8'h01);
        tick();
        tick();
        check("rip_no_pulse", {7'd0, bus.out_valid}, 8'h00);
        check("rip_p_hold",   p, 8'h24);

        // Reset overrides a coincident p_load
        @(negedge clk);
        p_load = 1'b1;
        p_in   = 8'hFF;
        tick();
        p_load = 1'b0;
        check("pload_rst_p", p, 8'hFF);
        @(negedge clk);
        reset  = 1'b1;
        p_load = 1'b1;
        p_in   = 8'hDB;
        tick();
        reset  = 1'b0;
        p_load = 1'b0;
        check("rst_over_pload", p, 8'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
